// File: rtl/ccd_timing_pkg.sv
// Shared state type, TCD1500C default timing and the parameter legality check
// for the linear-CCD timing generator.
package ccd_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ccd_state_e;

  localparam int TCD_PIX_DIV   = 50;
  localparam int TCD_PIX_TOTAL = 2720;
  localparam int TCD_SH_LEN    = 2;
  localparam int TCD_DUMMY_PIX = 3;
  localparam int TCD_RS_ON     = 25;
  localparam int TCD_RS_OFF    = 40;
  localparam int TCD_SP_ON     = 10;
  localparam int TCD_SP_OFF    = 23;
  localparam int TCD_SAMPLE_AT = 45;

  function automatic bit ccd_params_ok(
    input int pix_div,
    input int pix_total,
    input int sh_len,
    input int dummy_pix,
    input int rs_on,
    input int rs_off,
    input int sp_on,
    input int sp_off,
    input int sample_at
  );
    return (pix_div >= 8) && (pix_div % 2 == 0) &&
           (rs_on < rs_off) && (rs_off < pix_div) &&
           (sp_on < sp_off) && (sp_off < pix_div) &&
           (sample_at < pix_div) &&
           (sh_len > 0) && (sh_len < pix_total) &&
           (dummy_pix < pix_total);
  endfunction

endpackage

// File: rtl/ccd_pix_counter.sv
// Sub-pixel counter (always running) and frame pixel counter, which is parked
// at 0 while hold_pix is set.
module ccd_pix_counter #(
  parameter int PIX_DIV   = 50,
  parameter int PIX_TOTAL = 2720,
  parameter int SW        = $clog2(PIX_DIV),
  parameter int PW        = $clog2(PIX_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_pix,
  output logic [SW-1:0] sub,
  output logic [PW-1:0] pix,
  output logic          sub_last,
  output logic          frame_last
);

  localparam logic [SW-1:0] SUB_MAX = SW'(PIX_DIV - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(PIX_TOTAL - 1);

  logic [SW-1:0] sub_q, sub_d;
  logic [PW-1:0] pix_q, pix_d;

  always_comb begin
    sub_last   = (sub_q == SUB_MAX);
    frame_last = sub_last && (pix_q == PIX_MAX);
    sub_d      = sub_last ? '0 : sub_q + 1'b1;
    pix_d      = pix_q;
    if (hold_pix) begin
      pix_d = '0;
    end else if (sub_last) begin
      pix_d = (pix_q == PIX_MAX) ? '0 : pix_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= '0;
      pix_q <= '0;
    end else begin
      sub_q <= sub_d;
      pix_q <= pix_d;
    end
  end

  assign sub = sub_q;
  assign pix = pix_q;

endmodule

// File: rtl/ccd_timing_gen.sv
// Linear-CCD timing generator: frame sequencing plus registered phi/sh/rs/sp,
// ADC pixel strobe/index and frame flags, all one clock behind the counters.
//   state    | meaning
//   IDLE     | pix parked at 0, sub and phi keep running, gates low
//   RUN      | frame in progress; wraps into the next frame when continuous
//   STOPPING | finishing the current frame, then IDLE
module ccd_timing_gen
  import ccd_timing_pkg::*;
#(
  parameter int PIX_DIV   = TCD_PIX_DIV,
  parameter int PIX_TOTAL = TCD_PIX_TOTAL,
  parameter int SH_LEN    = TCD_SH_LEN,
  parameter int DUMMY_PIX = TCD_DUMMY_PIX,
  parameter int RS_ON     = TCD_RS_ON,
  parameter int RS_OFF    = TCD_RS_OFF,
  parameter int SP_ON     = TCD_SP_ON,
  parameter int SP_OFF    = TCD_SP_OFF,
  parameter int SAMPLE_AT = TCD_SAMPLE_AT,
  parameter int PW        = $clog2(PIX_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          mode_single,
  input  logic          trig,
  input  logic [PW-1:0] cfg_int_pix,
  output logic          phi,
  output logic          sh,
  output logic          rs,
  output logic          sp,
  output logic          pix_strobe,
  output logic [PW-1:0] pix_idx,
  output logic          frame_start,
  output logic          frame_done,
  output logic          busy
);

  localparam int SW = $clog2(PIX_DIV);
  localparam logic [SW-1:0] RS_ON_S   = SW'(RS_ON);
  localparam logic [SW-1:0] RS_OFF_S  = SW'(RS_OFF);
  localparam logic [SW-1:0] SP_ON_S   = SW'(SP_ON);
  localparam logic [SW-1:0] SP_OFF_S  = SW'(SP_OFF);
  localparam logic [SW-1:0] SAMPLE_S  = SW'(SAMPLE_AT);
  localparam logic [PW-1:0] SH_LEN_P  = PW'(SH_LEN);
  localparam logic [PW-1:0] DUMMY_P   = PW'(DUMMY_PIX);
  localparam logic [PW:0]   SH_LEN_W  = (PW+1)'(SH_LEN);
  localparam logic [PW:0]   PIX_TOT_W = (PW+1)'(PIX_TOTAL);

  if (!ccd_params_ok(PIX_DIV, PIX_TOTAL, SH_LEN, DUMMY_PIX, RS_ON, RS_OFF,
                     SP_ON, SP_OFF, SAMPLE_AT)) begin : g_param_check
    $error("ccd_timing_gen: illegal timing parameters");
  end

  logic [SW-1:0] sub;
  logic [PW-1:0] pix;
  logic          sub_last, frame_last;

  ccd_state_e    state_q, state_d;
  logic          frame_go;
  logic          trig_q, trig_d, mode_q, mode_d;
  logic [PW-1:0] int_q, int_d;

  logic          active, pix_live, shut_hit;
  logic [PW:0]   shut_end;
  logic          phi_tog_q, phi_tog_d, phi_q, phi_d, sh_q, sh_d, rs_q, rs_d, sp_q, sp_d;
  logic          strobe_q, strobe_d, fs_q, fs_d, fd_q, fd_d, busy_q, busy_d;
  logic [PW-1:0] idx_q, idx_d;

  ccd_pix_counter #(
    .PIX_DIV  (PIX_DIV),
    .PIX_TOTAL(PIX_TOTAL),
    .SW       (SW),
    .PW       (PW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_pix  (state_q == IDLE),
    .sub       (sub),
    .pix       (pix),
    .sub_last  (sub_last),
    .frame_last(frame_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    frame_go = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sub_last && enable && (!mode_single || trig_q)) begin
          state_d  = RUN;
          frame_go = 1'b1;
        end
      end
      RUN: begin
        if (frame_last) begin
          if (enable && !mode_q) frame_go = 1'b1;
          else                   state_d  = IDLE;
        end else if (!enable || mode_q) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (frame_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-frame context: mode and shutter position are frozen when a frame begins.
  always_comb begin
    trig_d = trig_q;
    mode_d = mode_q;
    int_d  = int_q;
    if ((state_q == IDLE) && enable && trig) trig_d = 1'b1;
    if (frame_go) begin
      trig_d = 1'b0;
      mode_d = mode_single;
      int_d  = cfg_int_pix;
    end
  end

  always_comb begin
    active    = (state_q != IDLE);
    pix_live  = (pix >= DUMMY_P);
    shut_end  = {1'b0, int_q} + SH_LEN_W;
    shut_hit  = (int_q != '0) && (shut_end <= PIX_TOT_W) &&
                (pix >= int_q) && ({1'b0, pix} < shut_end);
    sh_d      = active && ((pix < SH_LEN_P) || shut_hit);
    phi_tog_d = (sub == '0) ? ~phi_tog_q : phi_tog_q;
    phi_d     = phi_tog_d | sh_d;
    rs_d      = active && (sub >= RS_ON_S) && (sub < RS_OFF_S);
    sp_d      = active && pix_live && (sub >= SP_ON_S) && (sub < SP_OFF_S);
    strobe_d  = active && pix_live && (sub == SAMPLE_S);
    idx_d     = strobe_d ? pix - DUMMY_P : idx_q;
    fs_d      = active && (pix == '0) && (sub == '0);
    fd_d      = active && frame_last;
    busy_d    = active;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      mode_q    <= 1'b0;
      int_q     <= '0;
      phi_tog_q <= 1'b0;
      phi_q     <= 1'b0;
      sh_q      <= 1'b0;
      rs_q      <= 1'b0;
      sp_q      <= 1'b0;
      strobe_q  <= 1'b0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      trig_q    <= trig_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
      phi_tog_q <= phi_tog_d;
      phi_q     <= phi_d;
      sh_q      <= sh_d;
      rs_q      <= rs_d;
      sp_q      <= sp_d;
      strobe_q  <= strobe_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      busy_q    <= busy_d;
    end
  end

  assign phi         = phi_q;
  assign sh          = sh_q;
  assign rs          = rs_q;
  assign sp          = sp_q;
  assign pix_strobe  = strobe_q;
  assign pix_idx     = idx_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen with a scaled-down sensor (8 clk/pixel,
// 20 pixels) so whole frames fit in a short run.
module tb_ccd_timing_gen;

  localparam int PIX_DIV   = 8;
  localparam int PIX_TOTAL = 20;
  localparam int SH_LEN    = 2;
  localparam int DUMMY_PIX = 3;
  localparam int RS_ON     = 3;
  localparam int RS_OFF    = 5;
  localparam int SP_ON     = 1;
  localparam int SP_OFF    = 3;
  localparam int SAMPLE_AT = 6;
  localparam int PW        = $clog2(PIX_TOTAL);
  localparam int FRAME     = PIX_DIV * PIX_TOTAL;

  logic          clk = 1'b0;
  logic          rst_n, enable, mode_single, trig;
  logic [PW-1:0] cfg_int_pix;
  logic          phi, sh, rs, sp, pix_strobe, frame_start, frame_done, busy;
  logic [PW-1:0] pix_idx;

  ccd_timing_gen #(
    .PIX_DIV  (PIX_DIV),
    .PIX_TOTAL(PIX_TOTAL),
    .SH_LEN   (SH_LEN),
    .DUMMY_PIX(DUMMY_PIX),
    .RS_ON    (RS_ON),
    .RS_OFF   (RS_OFF),
    .SP_ON    (SP_ON),
    .SP_OFF   (SP_OFF),
    .SAMPLE_AT(SAMPLE_AT),
    .PW       (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode_single(mode_single),
    .trig       (trig),
    .cfg_int_pix(cfg_int_pix),
    .phi        (phi),
    .sh         (sh),
    .rs         (rs),
    .sp         (sp),
    .pix_strobe (pix_strobe),
    .pix_idx    (pix_idx),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Offset o of a captured frame holds the pins driven by counter position o.
  logic [FRAME-1:0] sh_v, rs_v, sp_v, stb_v, fs_v, fd_v, busy_v, phi_v;
  int idx_bad, idx_last, idx_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fs(input int budget, output int n, output int fd_seen);
    bit hit = 1'b0;
    n = 0;
    fd_seen = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done) fd_seen++;
      hit = frame_start;
    end
    if (!hit) n = -1;
  endtask

  // Called at the negedge where frame_start is high.
  task automatic capture(input int chg_off, input logic [PW-1:0] chg_val,
                         input int en_off, input int trig_off);
    int k = 0;
    idx_bad  = 0;
    idx_last = -1;
    idx_hold = -1;
    for (int o = 0; o < FRAME; o++) begin
      if (o > 0) @(negedge clk);
      sh_v[o]   = sh;
      rs_v[o]   = rs;
      sp_v[o]   = sp;
      stb_v[o]  = pix_strobe;
      fs_v[o]   = frame_start;
      fd_v[o]   = frame_done;
      busy_v[o] = busy;
      phi_v[o]  = phi;
      if (pix_strobe) begin
        if (int'(pix_idx) != k) idx_bad++;
        idx_last = int'(pix_idx);
        k++;
      end
      if (o == FRAME - 1) idx_hold = int'(pix_idx);
      if (o == chg_off) cfg_int_pix = chg_val;
      if (o == en_off) enable = 1'b0;
      if (o == trig_off) trig = 1'b1;
      if (o == trig_off + 1) trig = 1'b0;
    end
  endtask

  task automatic idle_win(input int n, output int act, output int busy_n, output int phi_tg);
    logic prev = 1'b0;
    act = 0;
    busy_n = 0;
    phi_tg = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sh || rs || sp || pix_strobe || frame_start || frame_done) act++;
      if (busy) busy_n++;
      if (i > 0 && phi !== prev) phi_tg++;
      prev = phi;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fdn, act, bn, tg, bad;
    rst_n = 1'b0; enable = 1'b0; mode_single = 1'b0; trig = 1'b0; cfg_int_pix = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'({phi, sh, rs, sp, pix_strobe, frame_start, frame_done, busy}), 0);
    chk("rst_idx", 32'(pix_idx), 0);

    // Continuous mode, first frame; shutter change mid-frame must not apply yet.
    rst_n = 1'b1; enable = 1'b1;
    wait_fs(40, n, fdn);
    chk("start_lat", n, 9);
    chk("start_no_fd", fdn, 0);
    capture(80, PW'(10), -1, -1);
    chk("f1_fs_once", $countones(fs_v), 1);
    chk("f1_fd_cnt", $countones(fd_v), 1);
    chk("f1_fd_pos", 32'(fd_v[FRAME-1]), 1);
    chk("f1_sh_clks", $countones(sh_v), 16);
    chk("f1_sh_edge", 32'(sh_v[12 +: 8]), 'h0F);
    chk("f1_rs_clks", $countones(rs_v), 40);
    chk("f1_rs_pix5", 32'(rs_v[40 +: 8]), 'h18);
    chk("f1_sp_clks", $countones(sp_v), 34);
    chk("f1_sp_pix5", 32'(sp_v[40 +: 8]), 'h06);
    chk("f1_sp_first", 32'(sp_v[25:0]), 32'h0200_0000);
    chk("f1_stb_cnt", $countones(stb_v), 17);
    chk("f1_stb_pix5", 32'(stb_v[40 +: 8]), 'h40);
    chk("f1_stb_first", 32'(stb_v[30:0]), 32'h4000_0000);
    chk("f1_idx_seq", idx_bad, 0);
    chk("f1_idx_last", idx_last, 16);
    chk("f1_idx_hold", idx_hold, 16);
    chk("f1_busy", $countones(busy_v), FRAME);
    tg = 0; bad = 0;
    for (int o = 17; o < FRAME; o++) begin
      if (phi_v[o] !== phi_v[o-1]) begin
        tg++;
        if (o % PIX_DIV != 0) bad++;
      end
    end
    chk("f1_phi_toggles", tg, 17);
    chk("f1_phi_phase", bad, 0);
    wait_fs(5, n, fdn);
    chk("f1_fs_gap", n, 1);

    // Shutter at pixel 10, then an out-of-range value, then the last legal one.
    capture(50, PW'(19), -1, -1);
    chk("f2_sh_clks", $countones(sh_v), 32);
    chk("f2_sh_rise", 32'(sh_v[76 +: 8]), 'hF0);
    chk("f2_sh_fall", 32'(sh_v[92 +: 8]), 'h0F);
    wait_fs(5, n, fdn);
    chk("f2_fs_gap", n, 1);
    capture(20, PW'(18), -1, -1);
    chk("f3_sh_clks", $countones(sh_v), 16);
    wait_fs(5, n, fdn);
    chk("f3_fs_gap", n, 1);
    capture(20, PW'(0), -1, -1);
    chk("f4_sh_clks", $countones(sh_v), 32);
    chk("f4_sh_rise", 32'(sh_v[140 +: 8]), 'hF0);
    chk("f4_sh_tail", 32'(sh_v[152 +: 8]), 'hFF);
    wait_fs(5, n, fdn);
    chk("f4_fs_gap", n, 1);

    // Enable drops at pixel 8: frame still completes, then IDLE.
    capture(-1, '0, 64, -1);
    chk("f5_fd_pos", 32'(fd_v[FRAME-1]), 1);
    chk("f5_stb_cnt", $countones(stb_v), 17);
    chk("f5_busy", $countones(busy_v), FRAME);
    idle_win(40, act, bn, tg);
    chk("stop_act", act, 0);
    chk("stop_busy", bn, 0);
    chk("stop_phi", tg, 4);
    chk("stop_idx_hold", 32'(pix_idx), 16);

    // Single mode: trig with enable low is ignored, then one triggered frame.
    mode_single = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    enable = 1'b1;
    wait_fs(40, n, fdn);
    chk("trig_en0", n, -1);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_fs(40, n, fdn);
    chk("single_seen", 32'(n > 0), 1);
    capture(-1, '0, -1, 40);
    chk("single_fd_cnt", $countones(fd_v), 1);
    chk("single_fd_pos", 32'(fd_v[FRAME-1]), 1);
    chk("single_busy", $countones(busy_v), FRAME);
    chk("single_stb", $countones(stb_v), 17);
    idle_win(200, act, bn, tg);
    chk("single_act", act, 0);
    chk("single_busy_after", bn, 0);
    chk("single_phi", tg, 24);

    // Reset pulse mid-frame at pixel 12.
    mode_single = 1'b0;
    wait_fs(40, n, fdn);
    chk("r_fs_seen", 32'(n > 0), 1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_out", 32'({phi, sh, rs, sp, pix_strobe, frame_start, frame_done, busy}), 0);
    chk("r_idx", 32'(pix_idx), 0);
    rst_n = 1'b1;
    wait_fs(40, n, fdn);
    chk("r_restart", n, 9);
    chk("r_no_fd", fdn, 0);
    capture(-1, '0, -1, -1);
    chk("r_fd_pos", 32'(fd_v[FRAME-1]), 1);
    chk("r_stb_cnt", $countones(stb_v), 17);
    chk("r_idx_seq", idx_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
